// File: rtl/cpu_pkg.sv
// Shared core definitions: datapath widths, reset/halt encodings and the fetch state type.
package cpu_pkg;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned INSTR_W_DEF = 32;
  localparam int unsigned CNT_W_DEF   = 16;

  localparam logic [ADDR_W_DEF-1:0]  RESET_PC_DEF   = '0;
  localparam logic [INSTR_W_DEF-1:0] HALT_INSTR_DEF = '1;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALTED
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory read path, decode controls and IF/ID outputs.
interface fetch_stage_if
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
);

  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic               stall;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               if_id_valid;
  logic [INSTR_W-1:0] if_id_instr;
  logic [ADDR_W-1:0]  if_id_pc;
  logic               halted;
  logic [CNT_W-1:0]   fetch_count;

  modport master (
    output imem_addr,
    input  imem_instr,
    input  stall,
    input  redirect_valid,
    input  redirect_pc,
    output if_id_valid,
    output if_id_instr,
    output if_id_pc,
    output halted,
    output fetch_count
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output stall,
    output redirect_valid,
    output redirect_pc,
    input  if_id_valid,
    input  if_id_instr,
    input  if_id_pc,
    input  halted,
    input  fetch_count
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load captures a fetched word, bubble drops valid, otherwise hold.
module if_id_reg #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               bubble,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc
);

  // A bubble keeps the stale instr/pc; only the valid bit is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (bubble) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= instr_in;
      pc    <= pc_in;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives instruction memory, fills IF/ID, handles redirect/stall/HALT.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned        ADDR_W     = ADDR_W_DEF,
  parameter int unsigned        INSTR_W    = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
  parameter logic [INSTR_W-1:0] HALT_INSTR = '1,
  parameter int unsigned        CNT_W      = CNT_W_DEF
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);

  fetch_state_t       state, state_next;
  logic [ADDR_W-1:0]  pc, pc_next;
  logic [CNT_W-1:0]   cnt;
  logic               load, bubble, cnt_inc;
  logic               v_q;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  ipc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BOOT;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // Redirect outranks stall in every state; HALT latches the word but freezes the PC.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    load       = 1'b0;
    bubble     = 1'b0;
    cnt_inc    = 1'b0;
    unique case (state)
      BOOT: begin
        state_next = RUN;
        if (bus.redirect_valid) pc_next = bus.redirect_pc;
      end
      RUN: begin
        if (bus.redirect_valid) begin
          pc_next = bus.redirect_pc;
          bubble  = 1'b1;
        end else if (!bus.stall) begin
          load    = 1'b1;
          cnt_inc = 1'b1;
          if (bus.imem_instr == HALT_INSTR) state_next = HALTED;
          else                              pc_next    = pc + ADDR_W'(1);
        end
      end
      HALTED: begin
        if (bus.redirect_valid) begin
          pc_next    = bus.redirect_pc;
          state_next = RUN;
          bubble     = 1'b1;
        end else if (!bus.stall) begin
          bubble = 1'b1;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     cnt <= '0;
    else if (cnt_inc && cnt != '1) cnt <= cnt + CNT_W'(1);
  end

  if_id_reg #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_if_id (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .bubble   (bubble),
    .pc_in    (pc),
    .instr_in (bus.imem_instr),
    .valid    (v_q),
    .instr    (instr_q),
    .pc       (ipc_q)
  );

  assign bus.imem_addr   = pc;
  assign bus.if_id_valid = v_q;
  assign bus.if_id_instr = instr_q;
  assign bus.if_id_pc    = ipc_q;
  assign bus.halted      = (state == HALTED);
  assign bus.fetch_count = cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand-written corner sequences, randomized run vs model.
module tb_fetch_stage;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CNT_W   = 6;
  localparam logic [31:0] CMAX    = 32'd63;

  logic clk;
  logic reset;
  logic [31:0] halt_addr;
  int tests;
  int fails;

  fetch_stage_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) bus ();

  fetch_stage #(
    .ADDR_W     (ADDR_W),
    .INSTR_W    (INSTR_W),
    .RESET_PC   (32'd0),
    .HALT_INSTR (32'hFFFF_FFFF),
    .CNT_W      (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a == halt_addr) ? 32'hFFFF_FFFF : a + 32'd100;
  endfunction

  assign bus.imem_instr = imem(bus.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 0 = boot cycle, 1 = running, 2 = halted.
  int          m_mode;
  logic [31:0] m_pc, m_ipc, m_instr, m_cnt;
  logic        m_v;

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_ipc = 0; m_instr = 0; m_cnt = 0; m_v = 0;
  endtask

  task automatic model_step();
    logic [31:0] w;
    if (m_mode == 0) begin
      if (bus.redirect_valid) m_pc = bus.redirect_pc;
      m_mode = 1;
    end else if (bus.redirect_valid) begin
      m_pc = bus.redirect_pc; m_v = 0; m_mode = 1;
    end else if (!bus.stall) begin
      if (m_mode == 2) m_v = 0;
      else begin
        w = imem(m_pc);
        m_v = 1; m_instr = w; m_ipc = m_pc;
        if (m_cnt < CMAX) m_cnt = m_cnt + 1;
        if (w == 32'hFFFF_FFFF) m_mode = 2;
        else m_pc = m_pc + 32'd1;
      end
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("model_addr",  64'(bus.imem_addr),   64'(m_pc));
    check("model_valid", 64'(bus.if_id_valid), 64'(m_v));
    check("model_halt",  64'(bus.halted),      64'(m_mode == 2));
    check("model_count", 64'(bus.fetch_count), 64'(m_cnt));
    if (m_v) begin
      check("model_ipc",   64'(bus.if_id_pc),    64'(m_ipc));
      check("model_instr", 64'(bus.if_id_instr), 64'(m_instr));
    end
  endtask

  task automatic step_check();
    model_step();
    @(posedge clk); #1;
    check_model();
  endtask

  task automatic drive(input logic s, input logic rv, input logic [31:0] rpc);
    bus.stall = s; bus.redirect_valid = rv; bus.redirect_pc = rpc;
  endtask

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        v;
    logic [31:0] ipc;
    logic [31:0] instr;
    logic [31:0] addr;
    logic        h;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[20];

  initial begin
    tests = 0; fails = 0;
    halt_addr = 32'd9;
    drive(0, 0, 0);
    model_reset();

    tbl[0]  = '{0, 0, 32'd0,  0, 32'd0,  32'd0,   32'd0,  0, 32'd0};
    tbl[1]  = '{0, 0, 32'd0,  1, 32'd0,  32'd100, 32'd1,  0, 32'd1};
    tbl[2]  = '{0, 0, 32'd0,  1, 32'd1,  32'd101, 32'd2,  0, 32'd2};
    tbl[3]  = '{0, 0, 32'd0,  1, 32'd2,  32'd102, 32'd3,  0, 32'd3};
    tbl[4]  = '{0, 0, 32'd0,  1, 32'd3,  32'd103, 32'd4,  0, 32'd4};
    tbl[5]  = '{0, 0, 32'd0,  1, 32'd4,  32'd104, 32'd5,  0, 32'd5};
    tbl[6]  = '{1, 0, 32'd0,  1, 32'd4,  32'd104, 32'd5,  0, 32'd5};
    tbl[7]  = '{1, 0, 32'd0,  1, 32'd4,  32'd104, 32'd5,  0, 32'd5};
    tbl[8]  = '{0, 0, 32'd0,  1, 32'd5,  32'd105, 32'd6,  0, 32'd6};
    tbl[9]  = '{0, 0, 32'd0,  1, 32'd6,  32'd106, 32'd7,  0, 32'd7};
    tbl[10] = '{1, 1, 32'd20, 0, 32'd6,  32'd106, 32'd20, 0, 32'd7};
    tbl[11] = '{0, 0, 32'd0,  1, 32'd20, 32'd120, 32'd21, 0, 32'd8};
    tbl[12] = '{0, 1, 32'd8,  0, 32'd20, 32'd120, 32'd8,  0, 32'd8};
    tbl[13] = '{0, 0, 32'd0,  1, 32'd8,  32'd108, 32'd9,  0, 32'd9};
    tbl[14] = '{0, 0, 32'd0,  1, 32'd9,  32'hFFFF_FFFF, 32'd9, 1, 32'd10};
    tbl[15] = '{1, 0, 32'd0,  1, 32'd9,  32'hFFFF_FFFF, 32'd9, 1, 32'd10};
    tbl[16] = '{0, 0, 32'd0,  0, 32'd9,  32'hFFFF_FFFF, 32'd9, 1, 32'd10};
    tbl[17] = '{0, 0, 32'd0,  0, 32'd9,  32'hFFFF_FFFF, 32'd9, 1, 32'd10};
    tbl[18] = '{0, 1, 32'd2,  0, 32'd9,  32'hFFFF_FFFF, 32'd2, 0, 32'd10};
    tbl[19] = '{0, 0, 32'd0,  1, 32'd2,  32'd102, 32'd3,  0, 32'd11};

    // Reset values while held in reset.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_addr",  64'(bus.imem_addr),   64'd0);
    check("rst_valid", 64'(bus.if_id_valid), 64'd0);
    check("rst_instr", 64'(bus.if_id_instr), 64'd0);
    check("rst_ipc",   64'(bus.if_id_pc),    64'd0);
    check("rst_halt",  64'(bus.halted),      64'd0);
    check("rst_count", 64'(bus.fetch_count), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].stall, tbl[i].rv, tbl[i].rpc);
      model_step();
      @(posedge clk); #1;
      check($sformatf("vec%0d_valid", i), 64'(bus.if_id_valid), 64'(tbl[i].v));
      check($sformatf("vec%0d_ipc", i),   64'(bus.if_id_pc),    64'(tbl[i].ipc));
      check($sformatf("vec%0d_instr", i), 64'(bus.if_id_instr), 64'(tbl[i].instr));
      check($sformatf("vec%0d_addr", i),  64'(bus.imem_addr),   64'(tbl[i].addr));
      check($sformatf("vec%0d_halt", i),  64'(bus.halted),      64'(tbl[i].h));
      check($sformatf("vec%0d_count", i), 64'(bus.fetch_count), 64'(tbl[i].cnt));
    end
    drive(0, 0, 0);

    // Run to pc 12, then pulse reset between edges.
    halt_addr = 32'hFFFF_0000;
    repeat (9) step_check();
    check("pre_reset_addr", 64'(bus.imem_addr), 64'd12);
    #2 reset = 1'b1;
    #1;
    check("async_addr",  64'(bus.imem_addr),   64'd0);
    check("async_count", 64'(bus.fetch_count), 64'd0);
    check("async_valid", 64'(bus.if_id_valid), 64'd0);
    check("async_halt",  64'(bus.halted),      64'd0);
    reset = 1'b0;
    model_reset();
    step_check();
    check("reboot_valid", 64'(bus.if_id_valid), 64'd0);
    check("reboot_addr",  64'(bus.imem_addr),   64'd0);
    step_check();
    check("reboot_ipc", 64'(bus.if_id_pc), 64'd0);

    // PC wrap from all-ones.
    drive(0, 1, 32'hFFFF_FFFF);
    step_check();
    drive(0, 0, 0);
    step_check();
    check("wrap_addr",  64'(bus.imem_addr),   64'd0);
    check("wrap_ipc",   64'(bus.if_id_pc),    64'hFFFF_FFFF);
    check("wrap_instr", 64'(bus.if_id_instr), 64'd99);

    // Counter saturation.
    repeat (70) step_check();
    check("sat_count", 64'(bus.fetch_count), 64'(CMAX));
    step_check();
    check("sat_hold", 64'(bus.fetch_count), 64'(CMAX));

    // Randomized traffic with occasional mid-cycle resets.
    for (int c = 0; c < 600; c++) begin
      if (c % 50 == 0) halt_addr = 32'($urandom_range(0, 40));
      if (c % 150 == 75) begin
        #2 reset = 1'b1;
        #1 reset = 1'b0;
        model_reset();
        check("rand_rst_addr", 64'(bus.imem_addr), 64'd0);
      end
      bus.stall          = ($urandom_range(0, 3) == 0);
      bus.redirect_valid = ($urandom_range(0, 7) == 0);
      bus.redirect_pc    = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFE
                                                       : 32'($urandom_range(0, 40));
      step_check();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
